// File: rtl/puf_arb_pkg.sv
// Shared types and default parameters for the PUF core arbiter.
// Optional AUTH_WAIT watchdog is enabled by defining PUF_ARB_TIMEOUT_EN.
package puf_arb_pkg;

  localparam int DEF_CHAL_W      = 128;
  localparam int DEF_RESP_W      = 256;
  localparam int DEF_RNG_BURST   = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AUTH_LOAD = 3'd1,
    ST_AUTH_WAIT = 3'd2,
    ST_RNG_RUN   = 3'd3,
    ST_DRAIN     = 3'd4
  } puf_arb_state_e;

  typedef enum logic {
    GNT_AUTH = 1'b0,
    GNT_RNG  = 1'b1
  } puf_arb_grant_e;

endpackage

// File: rtl/puf_arb_timer.sv
// RNG nibble counter and optional AUTH_WAIT watchdog for puf_arbiter.
// The watchdog exists only when PUF_ARB_TIMEOUT_EN is defined.
module puf_arb_timer
  import puf_arb_pkg::*;
#(
  parameter int RNG_BURST   = DEF_RNG_BURST,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_rng_run,
  input  logic i_rng_done,
  input  logic i_auth_wait,
  output logic o_burst_hit,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(RNG_BURST + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_nib_cnt;

  // Held at zero outside RNG_RUN so every session starts from a fresh count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nib_cnt <= '0;
    end else if (!i_rng_run) begin
      r_nib_cnt <= '0;
    end else if (i_rng_done && (r_nib_cnt != CNT_W'(RNG_BURST))) begin
      r_nib_cnt <= r_nib_cnt + CNT_W'(1);
    end
  end

  // Burst is reached either already, or by the nibble completing this cycle.
  assign o_burst_hit = i_rng_run &&
                       ((r_nib_cnt == CNT_W'(RNG_BURST)) ||
                        (i_rng_done && (r_nib_cnt == CNT_W'(RNG_BURST - 1))));

`ifdef PUF_ARB_TIMEOUT_EN
  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_cnt <= '0;
    end else if (!i_auth_wait) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != WD_W'(TIMEOUT_CYC - 1)) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Fires on the last permitted wait cycle; the error strobe lands one cycle later.
  assign o_timeout = i_auth_wait && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  logic [WD_W-1:0] w_unused_wait;
  assign w_unused_wait = {WD_W{i_auth_wait}};
  assign o_timeout     = 1'b0;
`endif

endmodule

// File: rtl/puf_arbiter.sv
// Arbitrates the shared PUF core between challenge-response auth and RNG sessions.
// Define PUF_ARB_TIMEOUT_EN to enable the AUTH_WAIT watchdog (auth_err_o).
module puf_arbiter
  import puf_arb_pkg::*;
#(
  parameter int CHAL_W      = DEF_CHAL_W,
  parameter int RESP_W      = DEF_RESP_W,
  parameter int RNG_BURST   = DEF_RNG_BURST,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              auth_req_i,
  input  logic [CHAL_W-1:0] auth_chal_i,
  output logic              auth_ack_o,
  output logic [RESP_W-1:0] auth_resp_o,
  output logic              auth_valid_o,
  output logic              auth_err_o,
  input  logic              rng_req_i,
  output logic [3:0]        rng_data_o,
  output logic              rng_valid_o,
  output logic              core_enable_o,
  output logic              core_mode_o,
  output logic              core_ready_cha_o,
  output logic [CHAL_W-1:0] core_chal_o,
  input  logic [RESP_W-1:0] core_resp_i,
  input  logic              core_resp_valid_i,
  input  logic [3:0]        core_rng4bit_i,
  input  logic              core_rng_done_i,
  output logic              busy_o,
  output logic [2:0]        dbg_state_o
);

  // Handshakes: auth_req_i is a level held until the one-cycle auth_ack_o, and the
  // challenge is sampled on the grant edge. auth_valid_o, auth_err_o and rng_valid_o
  // are one-cycle strobes with no back-pressure; consumers must take them as they come.

  puf_arb_state_e    r_state;
  puf_arb_state_e    w_state_nxt;
  puf_arb_grant_e    r_last_grant;
  logic [CHAL_W-1:0] r_chal;
  logic [RESP_W-1:0] r_resp;
  logic [3:0]        r_rng_data;
  logic              r_auth_valid;
  logic              r_auth_err;
  logic              r_rng_valid;
  logic              r_mode;

  logic w_in_wait;
  logic w_in_rng;
  logic w_grant_auth;
  logic w_burst_hit;
  logic w_timeout;

  assign w_in_wait    = (r_state == ST_AUTH_WAIT);
  assign w_in_rng     = (r_state == ST_RNG_RUN);
  // Round-robin on contention: auth wins unless it was the last one granted.
  assign w_grant_auth = auth_req_i && (!rng_req_i || (r_last_grant == GNT_RNG));

  puf_arb_timer #(
    .RNG_BURST   (RNG_BURST),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_rng_run   (w_in_rng),
    .i_rng_done  (core_rng_done_i),
    .i_auth_wait (w_in_wait),
    .o_burst_hit (w_burst_hit),
    .o_timeout   (w_timeout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_auth) begin
          w_state_nxt = ST_AUTH_LOAD;
        end else if (rng_req_i) begin
          w_state_nxt = ST_RNG_RUN;
        end
      end
      ST_AUTH_LOAD: w_state_nxt = ST_AUTH_WAIT;
      ST_AUTH_WAIT: begin
        if (core_resp_valid_i || w_timeout) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_RNG_RUN: begin
        if (!rng_req_i || (auth_req_i && w_burst_hit)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_RNG;
      r_chal       <= '0;
      r_resp       <= '0;
      r_rng_data   <= '0;
      r_auth_valid <= 1'b0;
      r_auth_err   <= 1'b0;
      r_rng_valid  <= 1'b0;
      r_mode       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_auth_valid <= w_in_wait && core_resp_valid_i;
      r_auth_err   <= w_in_wait && w_timeout && !core_resp_valid_i;
      // A nibble finishing on the exit cycle is still delivered.
      r_rng_valid  <= w_in_rng && core_rng_done_i;
      if (w_in_wait && core_resp_valid_i) begin
        r_resp <= core_resp_i;
      end
      if (w_in_rng && core_rng_done_i) begin
        r_rng_data <= core_rng4bit_i;
      end
      // Mode is only updated on the grant edge, i.e. while the core is disabled.
      if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) begin
        r_mode       <= (w_state_nxt == ST_RNG_RUN);
        r_last_grant <= (w_state_nxt == ST_RNG_RUN) ? GNT_RNG : GNT_AUTH;
      end
      if ((r_state == ST_IDLE) && w_grant_auth) begin
        r_chal <= auth_chal_i;
      end
    end
  end

  assign auth_ack_o       = (r_state == ST_AUTH_LOAD);
  assign core_ready_cha_o = (r_state == ST_AUTH_LOAD);
  assign core_enable_o    = (r_state == ST_AUTH_LOAD) || w_in_wait || w_in_rng;
  assign core_mode_o      = r_mode;
  assign core_chal_o      = r_chal;
  assign auth_resp_o      = r_resp;
  assign auth_valid_o     = r_auth_valid;
  assign auth_err_o       = r_auth_err;
  assign rng_data_o       = r_rng_data;
  assign rng_valid_o      = r_rng_valid;
  assign busy_o           = (r_state != ST_IDLE);
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_puf_arbiter.sv
// Self-checking bench for puf_arbiter; define PUF_ARB_TIMEOUT_EN to exercise the watchdog.
// Expected nibbles/responses come from the bench's own sequencing via scoreboard queues.
module tb_puf_arbiter;

  localparam int CHAL_W      = 128;
  localparam int RESP_W      = 256;
  localparam int RNG_BURST   = 16;
  localparam int TIMEOUT_CYC = 1024;

  logic              clk_i;
  logic              rst_ni;
  logic              auth_req_i;
  logic [CHAL_W-1:0] auth_chal_i;
  logic              auth_ack_o;
  logic [RESP_W-1:0] auth_resp_o;
  logic              auth_valid_o;
  logic              auth_err_o;
  logic              rng_req_i;
  logic [3:0]        rng_data_o;
  logic              rng_valid_o;
  logic              core_enable_o;
  logic              core_mode_o;
  logic              core_ready_cha_o;
  logic [CHAL_W-1:0] core_chal_o;
  logic [RESP_W-1:0] core_resp_i;
  logic              core_resp_valid_i;
  logic [3:0]        core_rng4bit_i;
  logic              core_rng_done_i;
  logic              busy_o;
  logic [2:0]        dbg_state_o;

  int n_vec  = 0;
  int n_miss = 0;
  int n_auth = 0;
  int n_rng  = 0;
  int n_err  = 0;
  int exp_auth = 0;
  int exp_rng  = 0;
  int exp_err  = 0;

  logic [3:0]        exp_q[$];
  logic [RESP_W-1:0] resp_q[$];
  logic [RESP_W-1:0] last_resp = '0;
  logic              prev_en   = 1'b0;
  logic              prev_mode = 1'b0;

  puf_arbiter #(
    .CHAL_W      (CHAL_W),
    .RESP_W      (RESP_W),
    .RNG_BURST   (RNG_BURST),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .auth_req_i        (auth_req_i),
    .auth_chal_i       (auth_chal_i),
    .auth_ack_o        (auth_ack_o),
    .auth_resp_o       (auth_resp_o),
    .auth_valid_o      (auth_valid_o),
    .auth_err_o        (auth_err_o),
    .rng_req_i         (rng_req_i),
    .rng_data_o        (rng_data_o),
    .rng_valid_o       (rng_valid_o),
    .core_enable_o     (core_enable_o),
    .core_mode_o       (core_mode_o),
    .core_ready_cha_o  (core_ready_cha_o),
    .core_chal_o       (core_chal_o),
    .core_resp_i       (core_resp_i),
    .core_resp_valid_i (core_resp_valid_i),
    .core_rng4bit_i    (core_rng4bit_i),
    .core_rng_done_i   (core_rng_done_i),
    .busy_o            (busy_o),
    .dbg_state_o       (dbg_state_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [RESP_W-1:0] got, input logic [RESP_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  function automatic logic [RESP_W-1:0] rand_resp();
    logic [RESP_W-1:0] r;
    for (int i = 0; i < RESP_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [CHAL_W-1:0] rand_chal();
    logic [CHAL_W-1:0] c;
    for (int i = 0; i < CHAL_W / 32; i++) c[i*32 +: 32] = $urandom;
    return c;
  endfunction

  // Scoreboard: every strobe must match the oldest expected item; mode must not change while enabled.
  always @(posedge clk_i) begin
    #1;
    if (rng_valid_o) begin
      n_rng++;
      if (exp_q.size() == 0) chk("rng_spurious", 1'b1, 1'b0);
      else chk("rng_data", rng_data_o, exp_q.pop_front());
    end
    if (auth_valid_o) begin
      n_auth++;
      if (resp_q.size() == 0) chk("auth_spurious", 1'b1, 1'b0);
      else chk("auth_resp", auth_resp_o, resp_q.pop_front());
    end
    if (auth_err_o) n_err++;
    if (prev_en && core_enable_o) chk("mode_stable", core_mode_o, prev_mode);
    prev_en   = core_enable_o;
    prev_mode = core_mode_o;
  end

  // Driver tasks: each starts and ends on a negedge with the arbiter idle unless noted.
  task automatic auth_start(input logic [CHAL_W-1:0] chal);
    auth_req_i  = 1'b1;
    auth_chal_i = chal;
    step(1);
    chk("ack", auth_ack_o, 1'b1);
    chk("ready_cha", core_ready_cha_o, 1'b1);
    chk("chal_out", core_chal_o, chal);
    chk("load_en_mode", {core_enable_o, core_mode_o}, 2'b10);
    auth_req_i  = 1'b0;
    auth_chal_i = ~chal;
    step(1);
    chk("ack_pulse", {auth_ack_o, core_ready_cha_o}, 2'b00);
    chk("wait_en_mode_busy", {core_enable_o, core_mode_o, busy_o}, 3'b101);
    chk("chal_hold", core_chal_o, chal);
  endtask

  task automatic do_auth(input logic [CHAL_W-1:0] chal, input logic [RESP_W-1:0] resp, input int lat);
    auth_start(chal);
    for (int i = 1; i < lat; i++) begin
      core_rng_done_i = 1'($urandom_range(0, 1));
      core_rng4bit_i  = 4'($urandom);
      step(1);
    end
    core_rng_done_i   = 1'b0;
    core_resp_valid_i = 1'b1;
    core_resp_i       = resp;
    resp_q.push_back(resp);
    exp_auth++;
    last_resp = resp;
    step(1);
    core_resp_valid_i = 1'b0;
    core_resp_i       = ~resp;
    chk("auth_valid", auth_valid_o, 1'b1);
    chk("auth_drain", {core_enable_o, busy_o}, 2'b01);
    step(1);
    chk("auth_idle", {busy_o, auth_valid_o}, 2'b00);
    chk("resp_hold", auth_resp_o, resp);
  endtask

  task automatic rng_gap();
    repeat ($urandom_range(0, 2)) begin
      core_resp_valid_i = 1'($urandom_range(0, 1));
      core_resp_i       = rand_resp();
      step(1);
      chk("rng_gap_quiet", rng_valid_o, 1'b0);
    end
    core_resp_valid_i = 1'b0;
  endtask

  task automatic rng_nibble(input logic [3:0] nib);
    core_rng_done_i = 1'b1;
    core_rng4bit_i  = nib;
    exp_q.push_back(nib);
    exp_rng++;
    step(1);
    core_rng_done_i = 1'b0;
    chk("rng_valid", rng_valid_o, 1'b1);
  endtask

  task automatic rng_close();
    rng_req_i = 1'b0;
    step(1);
    chk("rng_drain", {core_enable_o, busy_o}, 2'b01);
    step(1);
    chk("rng_idle", busy_o, 1'b0);
  endtask

  task automatic do_rng(input int n, input bit ramp);
    rng_req_i = 1'b1;
    step(1);
    chk("rng_en_mode_busy", {core_enable_o, core_mode_o, busy_o}, 3'b111);
    for (int i = 0; i < n; i++) begin
      rng_gap();
      rng_nibble(ramp ? 4'(3 + i) : 4'($urandom));
    end
    rng_close();
  endtask

  // After an auth finishes with rng_req_i still high, the RNG session follows one idle cycle later.
  task automatic rng_regrant();
    step(1);
    chk("regrant_rng", {core_enable_o, core_mode_o}, 2'b11);
    rng_close();
  endtask

  task automatic do_preempt(input logic [CHAL_W-1:0] chal);
    rng_req_i = 1'b1;
    step(1);
    chk("pre_rng_en", {core_enable_o, core_mode_o}, 2'b11);
    for (int i = 0; i < RNG_BURST; i++) begin
      if (i == 3) begin
        auth_req_i  = 1'b1;
        auth_chal_i = chal;
      end
      rng_gap();
      rng_nibble(4'($urandom));
      chk("preempt_en", core_enable_o, (i == RNG_BURST - 1) ? 1'b0 : 1'b1);
    end
    step(1);
    chk("preempt_idle", busy_o, 1'b0);
    do_auth(chal, rand_resp(), $urandom_range(1, 10));
    rng_regrant();
  endtask

  initial begin
    rst_ni            = 1'b0;
    auth_req_i        = 1'b0;
    auth_chal_i       = '0;
    rng_req_i         = 1'b0;
    core_resp_i       = '0;
    core_resp_valid_i = 1'b0;
    core_rng4bit_i    = '0;
    core_rng_done_i   = 1'b0;
    step(2);
    chk("reset_ctrl", {auth_ack_o, auth_valid_o, auth_err_o, rng_valid_o, rng_data_o,
                       core_enable_o, core_mode_o, core_ready_cha_o, busy_o, dbg_state_o}, '0);
    chk("reset_resp", auth_resp_o, '0);
    chk("reset_chal", core_chal_o, '0);
    rst_ni = 1'b1;
    step(1);

    do_auth({16{8'hA5}}, 256'h1234, 20);
    do_rng(10, 1'b1);

    // Simultaneous requests straight out of reset: auth first, then RNG.
    rst_ni = 1'b0;
    step(1);
    rst_ni = 1'b1;
    step(1);
    rng_req_i = 1'b1;
    do_auth(rand_chal(), rand_resp(), 5);
    rng_regrant();

    do_preempt(rand_chal());

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) do_auth(rand_chal(), rand_resp(), $urandom_range(1, 30));
      else do_rng($urandom_range(1, 8), 1'b0);
    end

`ifdef PUF_ARB_TIMEOUT_EN
    auth_start(rand_chal());
    step(TIMEOUT_CYC - 1);
    chk("wd_quiet", auth_err_o, 1'b0);
    chk("wd_still_wait", core_enable_o, 1'b1);
    step(1);
    chk("wd_err", auth_err_o, 1'b1);
    chk("wd_no_valid", auth_valid_o, 1'b0);
    chk("wd_resp_hold", auth_resp_o, last_resp);
    chk("wd_drain", {core_enable_o, busy_o}, 2'b01);
    exp_err = 1;
    step(1);
    chk("wd_idle", {busy_o, auth_err_o}, 2'b00);
    auth_start(rand_chal());
    step(3);
`else
    auth_start(rand_chal());
    step(5000);
    chk("no_wd_err", n_err, 0);
    chk("no_wd_wait", {core_enable_o, busy_o}, 2'b11);
`endif

    // Reset while waiting on the core: everything clears at once and nothing follows.
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_ctrl", {auth_ack_o, auth_valid_o, auth_err_o, rng_valid_o, rng_data_o,
                         core_enable_o, core_mode_o, core_ready_cha_o, busy_o, dbg_state_o}, '0);
    chk("rst_mid_resp", auth_resp_o, '0);
    chk("rst_mid_chal", core_chal_o, '0);
    core_resp_valid_i = 1'b1;
    core_resp_i       = rand_resp();
    step(1);
    rst_ni = 1'b1;
    step(1);
    core_resp_valid_i = 1'b0;
    step(10);
    chk("rst_mid_idle", busy_o, 1'b0);

    chk("auth_count", n_auth, exp_auth);
    chk("rng_count", n_rng, exp_rng);
    chk("err_count", n_err, exp_err);
    chk("resp_q_empty", resp_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/puf_arbiter.md
PUF_ARBITER -- requirements
Module: puf_arbiter

Interface
REQ-001 SHALL have parameter CHAL_W, default 128, meaning challenge width in bits.
REQ-002 SHALL have parameter RESP_W, default 256, meaning response width in bits.
REQ-003 SHALL have parameter RNG_BURST, default 16, meaning the maximum nibbles per RNG session while an auth request is pending.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the AUTH_WAIT watchdog limit in cycles.
REQ-005 SHALL have port clk_i, input, 1: sole clock.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port auth_req_i, input, 1: challenge-response request; held high until auth_ack_o.
REQ-008 SHALL have port auth_chal_i, input, CHAL_W: challenge; valid while auth_req_i=1.
REQ-009 SHALL have port auth_ack_o, input side consumed, output, 1: single-cycle grant pulse; the challenge is captured at this point.
REQ-010 SHALL have port auth_resp_o, output, RESP_W: registered response; holds its value until the next auth completion.
REQ-011 SHALL have port auth_valid_o, output, 1: single-cycle completion pulse.
REQ-012 SHALL have port auth_err_o, output, 1: single-cycle timeout pulse.
REQ-013 SHALL have port rng_req_i, input, 1: level entropy request from the entropy source.
REQ-014 SHALL have port rng_data_o, output, 4: registered nibble.
REQ-015 SHALL have port rng_valid_o, output, 1: single-cycle nibble strobe.
REQ-016 SHALL have port core_enable_o, output, 1, and core_mode_o, output, 1 (0=auth, 1=rng).
REQ-017 SHALL have port core_ready_cha_o, output, 1, and core_chal_o, output, CHAL_W.
REQ-018 SHALL have port core_resp_i, input, RESP_W, and core_resp_valid_i, input, 1.
REQ-019 SHALL have port core_rng4bit_i, input, 4, and core_rng_done_i, input, 1.
REQ-020 SHALL have port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, AUTH_LOAD, AUTH_WAIT, RNG_RUN and DRAIN.
REQ-022 In IDLE, SHALL behave as follows:
- auth only pending -> AUTH_LOAD, capturing auth_chal_i on that edge.
- rng only pending -> RNG_RUN.
- both pending -> grant the requester not granted last (last_grant register, reset = RNG, so auth wins first).
REQ-023 AUTH_LOAD SHALL last exactly 1 cycle:
- auth_ack_o=1, core_enable_o=1, core_mode_o=0, core_ready_cha_o=1.
- then -> AUTH_WAIT.
REQ-024 In AUTH_WAIT, SHALL hold core_enable_o=1 and core_mode_o=0.
- On core_resp_valid_i: register core_resp_i into auth_resp_o and pulse auth_valid_o the following cycle.
- Then -> DRAIN.
REQ-025 In RNG_RUN, SHALL hold core_enable_o=1 and core_mode_o=1.
- Each core_rng_done_i registers core_rng4bit_i and pulses rng_valid_o one cycle later.
REQ-026 SHALL count nibbles in RNG_RUN with a counter of width clog2(RNG_BURST+1), cleared on entry.
- Exit to DRAIN when rng_req_i=0.
- Also exit to DRAIN when count reaches RNG_BURST while auth_req_i=1 (preemption occurs only at a nibble boundary).
REQ-027 DRAIN SHALL last exactly 1 cycle with core_enable_o=0, then -> IDLE.
- core_mode_o SHALL change only while core_enable_o=0.
REQ-028 core_chal_o SHALL drive the captured challenge register at all times.
- Captured challenge reset value = 0.
REQ-029 SHALL ignore core_resp_valid_i outside AUTH_WAIT and core_rng_done_i outside RNG_RUN.
REQ-030 If core_rng_done_i coincides with the exit condition in RNG_RUN, SHALL still deliver that nibble.

Reset
REQ-031 SHALL asynchronously force the following on rst_ni=0:
- state=IDLE, last_grant=RNG, all counters=0.
- All outputs 0, including auth_resp_o and rng_data_o.
REQ-032 Reset mid-operation SHALL abandon the transaction with no valid/err pulse afterward.
- The requester re-requests.

Configuration
REQ-033 With PUF_ARB_TIMEOUT_EN defined, SHALL enable the AUTH_WAIT watchdog:
- A cycle counter is cleared on entry.
- When it reaches TIMEOUT_CYC with no core_resp_valid_i: pulse auth_err_o, keep auth_resp_o unchanged, suppress auth_valid_o, and go to DRAIN.
REQ-034 Without PUF_ARB_TIMEOUT_EN, SHALL omit the counter, tie auth_err_o to 0, and keep AUTH_WAIT waiting indefinitely.

Structure
REQ-035 SHALL place the following in package puf_arb_pkg:
- State enum puf_arb_state_e.
- Grant enum puf_arb_grant_e (GNT_AUTH, GNT_RNG).
- Default-parameter localparams.
REQ-036 SHALL implement the nibble counter plus optional watchdog as sub-module puf_arb_timer; the FSM remains in puf_arbiter.

Verification
REQ-037 Bench SHALL cover:
- auth_req_i=1, chal=128'hA5..A5, core returns resp 256'h1234 after 20 cycles -> ack at cycle 1, core_ready_cha_o for 1 cycle, auth_valid_o with resp=256'h1234, busy_o low 2 cycles later.
- rng_req_i held 10 nibbles, core_rng4bit_i=4'h3..4'hC -> 10 rng_valid_o pulses with matching data, each 1 cycle after done; DRAIN 1 cycle after rng_req_i falls.
- auth_req_i and rng_req_i rise together from reset -> auth granted first; then RNG granted after DRAIN.
- rng session active, auth_req_i raised -> exactly RNG_BURST=16 nibbles delivered, DRAIN, then auth ack.
- PUF_ARB_TIMEOUT_EN, no core response -> auth_err_o at cycle TIMEOUT_CYC=1024 after AUTH_WAIT entry, no auth_valid_o; without the macro -> no error pulse after 5000 cycles.
- rst_ni asserted in AUTH_WAIT -> all outputs 0 immediately; no pulses after release.
